message_forwarder: RTL and testbench

MESSAGE_FORWARDER -- requirements
Module: message_forwarder

---
 rtl/message_forwarder.sv | 136 +++++++++++++
 tb/tb_message_forwarder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_forwarder.sv
// message_forwarder
// Merges transit traffic from the receive side with locally originated
// messages onto one outbound GT link. Transit messages pass through a small
// FIFO; transit messages addressed to this FPGA are dropped and counted.
// One output register, refilled from either source with round-robin
// arbitration on ties.
//
// Handshake rule for every port: a message moves only in a cycle where valid
// and ready are both 1 at the rising clock edge. A valid source keeps its data
// stable until that edge.
module message_forwarder #(
    parameter int GT_FIFO_SIZE = 64,
    parameter int FPGA_ID      = 1,
    parameter int FWD_DEPTH    = 4,
    parameter int MSG_DEST_MSB = GT_FIFO_SIZE - 1,
    parameter int MSG_DEST_LSB = GT_FIFO_SIZE - 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [GT_FIFO_SIZE-1:0] fwd_data,
    input  logic                    fwd_valid,
    output logic                    fwd_ready,
    input  logic [GT_FIFO_SIZE-1:0] local_data,
    input  logic                    local_valid,
    output logic                    local_ready,
    output logic [GT_FIFO_SIZE-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    router_busy,
    output logic [7:0]              drop_count,
    output logic                    dbg_out_full
);

    localparam int PTR_W  = $clog2(FWD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DEST_W = MSG_DEST_MSB - MSG_DEST_LSB + 1;
    localparam logic [DEST_W-1:0] MY_ID = DEST_W'(FPGA_ID);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t              state;
    logic                    last_local;   // 1: last grant went to the local source
    logic [GT_FIFO_SIZE-1:0] mem [FWD_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;

    logic fwd_accept;
    logic drop_hit;
    logic push;
    logic pop;
    logic load_en;
    logic fifo_cand;
    logic grant_fwd;
    logic grant_local;

    // Forward-side acceptance depends on registered occupancy only
    assign fwd_ready  = (count < CNT_W'(FWD_DEPTH));
    assign fwd_accept = fwd_valid & fwd_ready;
    assign drop_hit   = fwd_accept & (fwd_data[MSG_DEST_MSB:MSG_DEST_LSB] == MY_ID);
    assign push       = fwd_accept & ~drop_hit;

    // Arbitration: the output register may take a new message when empty or draining
    assign load_en     = (state == EMPTY) | out_ready;
    assign fifo_cand   = (count != '0);
    assign grant_fwd   = load_en & fifo_cand & (~local_valid | last_local);
    assign grant_local = load_en & local_valid & (~fifo_cand | ~last_local);
    assign pop         = grant_fwd;
    assign local_ready = grant_local;

    assign out_valid    = (state == FULL);
    assign router_busy  = fifo_cand | out_valid;
    assign dbg_out_full = (state == FULL);

    // FIFO storage; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fwd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of 2)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of transit messages that were addressed to us
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= 8'd0;
        end else if (drop_hit && (drop_count != 8'hff)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Output register FSM: load the granted source, hold while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            last_local <= 1'b1;   // forward wins the first tie
        end else if (load_en) begin
            if (grant_fwd) begin
                out_data   <= mem[rd_ptr];
                state      <= FULL;
                last_local <= 1'b0;
            end else if (grant_local) begin
                out_data   <= local_data;
                state      <= FULL;
                last_local <= 1'b1;
            end else begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_message_forwarder.sv
// Bench for message_forwarder: directed scenarios plus a randomized run.
// Local messages carry bit0=1 and transit messages bit0=0 so the monitor can
// route each emitted message to the right per-source expected queue.
module tb_message_forwarder;

  localparam int W    = 64;
  localparam int ID   = 1;
  localparam int DMSB = W - 1;
  localparam int DLSB = W - 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] fwd_data;
  logic         fwd_valid;
  logic         fwd_ready;
  logic [W-1:0] local_data;
  logic         local_valid;
  logic         local_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         router_busy;
  logic [7:0]   drop_count;
  logic         dbg_out_full;

  message_forwarder #(
    .GT_FIFO_SIZE(W),
    .FPGA_ID     (ID),
    .FWD_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fwd_data    (fwd_data),
    .fwd_valid   (fwd_valid),
    .fwd_ready   (fwd_ready),
    .local_data  (local_data),
    .local_valid (local_valid),
    .local_ready (local_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .router_busy (router_busy),
    .drop_count  (drop_count),
    .dbg_out_full(dbg_out_full)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_fwd_q[$];
  logic [W-1:0] exp_loc_q[$];
  bit           tag_log[$];
  int           out_count = 0;
  int           exp_drop = 0;
  bit           fwd_xfer, loc_xfer, out_xfer, hold_pend;
  logic [W-1:0] hold_data;

  // driver controls
  int fwd_left = 0, loc_left = 0;
  int fwd_pct = 100, loc_pct = 100;
  int dest_mode = 0;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // dest_mode: 0 random (never us), 1 us, 2 broadcast, 3 mix of all
  function automatic logic [W-1:0] make_fwd();
    logic [W-1:0] d;
    int           m;
    d    = {$urandom, $urandom};
    d[0] = 1'b0;
    m    = dest_mode;
    if (m == 3) m = $urandom_range(0, 3);
    case (m)
      1:       d[DMSB:DLSB] = 8'(ID);
      2:       d[DMSB:DLSB] = 8'hff;
      default: if (d[DMSB:DLSB] == 8'(ID)) d[DMSB:DLSB] = 8'h81;
    endcase
    return d;
  endfunction

  function automatic logic [W-1:0] make_loc();
    logic [W-1:0] d;
    d    = {$urandom, $urandom};
    d[0] = 1'b1;
    return d;
  endfunction

  // driver: advance one cycle, retire accepted messages, offer new ones
  task automatic tick();
    @(posedge clk);
    #1;
    if (fwd_valid && fwd_xfer) fwd_valid = 1'b0;
    if (local_valid && loc_xfer) local_valid = 1'b0;
    if (!fwd_valid && fwd_left > 0 && $urandom_range(0, 99) < fwd_pct) begin
      fwd_data  = make_fwd();
      fwd_valid = 1'b1;
      fwd_left--;
    end
    if (!local_valid && loc_left > 0 && $urandom_range(0, 99) < loc_pct) begin
      local_data  = make_loc();
      local_valid = 1'b1;
      loc_left--;
    end
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    fwd_left    = 0;
    loc_left    = 0;
    fwd_valid   = 1'b0;
    local_valid = 1'b0;
    reset       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    int n;
    rand_ready = 0;
    out_ready  = 1'b1;
    fwd_left   = 0;
    loc_left   = 0;
    n = 0;
    while ((exp_fwd_q.size() != 0 || exp_loc_q.size() != 0 || fwd_valid || local_valid) && n < 500) begin
      tick();
      n++;
    end
    check("drain_fwd_q", W'(exp_fwd_q.size()), W'(0));
    check("drain_loc_q", W'(exp_loc_q.size()), W'(0));
  endtask

  // monitor: reference model of acceptance, drops, ordering and stall behaviour
  always @(negedge clk) begin
    if (!reset) begin
      fwd_xfer  = 1'b0;
      loc_xfer  = 1'b0;
      out_xfer  = 1'b0;
      hold_pend = 1'b0;
      exp_drop  = 0;
      exp_fwd_q.delete();
      exp_loc_q.delete();
    end else begin
      check("drop_count", W'(drop_count), W'(exp_drop));
      fwd_xfer = fwd_valid && fwd_ready;
      loc_xfer = local_valid && local_ready;
      out_xfer = out_valid && out_ready;
      if (fwd_xfer) begin
        if (fwd_data[DMSB:DLSB] == 8'(ID)) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          exp_fwd_q.push_back(fwd_data);
        end
      end
      if (loc_xfer) exp_loc_q.push_back(local_data);
      if (hold_pend) begin
        check("hold_valid", W'(out_valid), W'(1));
        check("hold_data", out_data, hold_data);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_xfer) begin
        out_count++;
        tag_log.push_back(out_data[0]);
        if (out_data[0]) begin
          if (exp_loc_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL local_extra: got %h expected nothing", out_data);
          end else begin
            check("local_order", out_data, exp_loc_q.pop_front());
          end
        end else begin
          if (exp_fwd_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL fwd_extra: got %h expected nothing", out_data);
          end else begin
            check("fwd_order", out_data, exp_fwd_q.pop_front());
          end
        end
      end
    end
  end

  // stimulus sequence
  initial begin
    int           base;
    int           n;
    logic [W-1:0] first;
    reset       = 1'b0;
    fwd_data    = '0;
    fwd_valid   = 1'b0;
    local_data  = '0;
    local_valid = 1'b0;
    out_ready   = 1'b0;

    // reset state
    repeat (2) at_neg();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_busy", W'(router_busy), W'(0));
    check("rst_drop", W'(drop_count), W'(0));
    check("rst_fwd_ready", W'(fwd_ready), W'(1));
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;

    // single local message, one-cycle latency
    tick();
    local_data  = W'(64'hA5);
    local_valid = 1'b1;
    at_neg();
    check("loc_ready_c0", W'(local_ready), W'(1));
    check("loc_busy_c0", W'(router_busy), W'(0));
    tick();
    at_neg();
    check("loc_valid_c1", W'(out_valid), W'(1));
    check("loc_data_c1", out_data, W'(64'hA5));
    tick();
    at_neg();
    check("loc_valid_c2", W'(out_valid), W'(0));

    // round-robin alternation F,L,F,L at full rate
    do_reset();
    out_ready = 1'b1;
    dest_mode = 0;
    fwd_pct   = 100;
    loc_pct   = 100;
    tag_log.delete();
    fwd_left = 40;
    tick();
    loc_left = 40;
    tick();
    tick();
    base = out_count;
    repeat (8) tick();
    check("rr_rate", W'(out_count - base), W'(8));
    for (int i = 0; i < 8; i++) check("rr_order", W'(tag_log[i]), W'(i % 2));
    drain();

    // stalled output: 1 in register, 4 in FIFO, then release in order
    do_reset();
    out_ready = 1'b0;
    dest_mode = 0;
    fwd_left  = 5;
    tick();
    first = fwd_data;
    repeat (6) tick();
    at_neg();
    check("stall_fwd_ready", W'(fwd_ready), W'(0));
    check("stall_valid", W'(out_valid), W'(1));
    check("stall_data", out_data, first);
    check("stall_busy", W'(router_busy), W'(1));
    check("stall_accepted", W'(exp_fwd_q.size()), W'(5));
    repeat (3) tick();
    at_neg();
    check("stall_data_late", out_data, first);
    drain();

    // misrouted transit messages are dropped; count saturates
    do_reset();
    out_ready = 1'b1;
    dest_mode = 1;
    base      = out_count;
    fwd_left  = 3;
    repeat (8) tick();
    check("drop_none_out", W'(out_count - base), W'(0));
    at_neg();
    check("drop_3", W'(drop_count), W'(3));
    fwd_left = 300;
    repeat (310) tick();
    at_neg();
    check("drop_sat", W'(drop_count), W'(255));
    check("drop_none_out2", W'(out_count - base), W'(0));

    // broadcast forwarded unchanged, 2-cycle latency
    dest_mode = 2;
    fwd_left  = 1;
    tick();
    first = fwd_data;
    at_neg();
    check("bc_fwd_ready", W'(fwd_ready), W'(1));
    tick();
    at_neg();
    check("bc_valid_c1", W'(out_valid), W'(0));
    tick();
    at_neg();
    check("bc_valid_c2", W'(out_valid), W'(1));
    check("bc_data_c2", out_data, first);
    drain();

    // asynchronous reset mid-operation discards everything
    out_ready = 1'b0;
    dest_mode = 0;
    fwd_left  = 4;
    repeat (7) tick();
    at_neg();
    check("mid_valid_pre", W'(out_valid), W'(1));
    check("mid_busy_pre", W'(router_busy), W'(1));
    @(posedge clk);
    #2;
    reset       = 1'b0;
    fwd_left    = 0;
    fwd_valid   = 1'b0;
    local_valid = 1'b0;
    #1;
    check("mid_valid", W'(out_valid), W'(0));
    check("mid_busy", W'(router_busy), W'(0));
    check("mid_data", out_data, W'(0));
    check("mid_fwd_ready", W'(fwd_ready), W'(1));
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    base      = out_count;
    repeat (10) tick();
    check("mid_nothing_out", W'(out_count - base), W'(0));

    // randomized traffic against the reference model
    do_reset();
    rand_ready = 1;
    dest_mode  = 3;
    fwd_left   = 300;
    loc_left   = 300;
    n = 0;
    while ((fwd_left > 0 || loc_left > 0) && n < 6000) begin
      if (n % 100 == 0) begin
        fwd_pct = $urandom_range(20, 100);
        loc_pct = $urandom_range(20, 100);
      end
      tick();
      n++;
    end
    check("rand_done", W'(fwd_left + loc_left), W'(0));
    drain();
    at_neg();
    check("rand_drop", W'(drop_count), W'(exp_drop > 255 ? 255 : exp_drop));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
